// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: initial hash words H0..H7, round count, and the K table.
package sha256_pkg;

  localparam int unsigned NumRounds = 64;

  localparam logic [31:0] H0 = 32'h6a09e667;
  localparam logic [31:0] H1 = 32'hbb67ae85;
  localparam logic [31:0] H2 = 32'h3c6ef372;
  localparam logic [31:0] H3 = 32'ha54ff53a;
  localparam logic [31:0] H4 = 32'h510e527f;
  localparam logic [31:0] H5 = 32'h9b05688c;
  localparam logic [31:0] H6 = 32'h1f83d9ab;
  localparam logic [31:0] H7 = 32'h5be0cd19;

  // H0 in the MSBs, matching the order the compression core unpacks it.
  localparam logic [255:0] IvWord = {H0, H1, H2, H3, H4, H5, H6, H7};

  // Round constants K[0..63]; referenced by other blocks and by benches.
  localparam logic [31:0] KTable [NumRounds] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_round_constants.sv
// SHA-256 constant ROM: registered round constant K_t (1-cycle latency) and constant IV.
module sha256_round_constants
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [6:0]   idx,
  output logic [31:0]  K_t,
  output logic [255:0] IV
);

  logic [31:0] k_d;
  logic [31:0] k_q;

  // Combinational K lookup; indices 64..127 fall to the default and yield zero.
  always_comb begin
    k_d = 32'h0000_0000;
    case (idx)
      7'd0:  k_d = 32'h428a2f98;
      7'd1:  k_d = 32'h71374491;
      7'd2:  k_d = 32'hb5c0fbcf;
      7'd3:  k_d = 32'he9b5dba5;
      7'd4:  k_d = 32'h3956c25b;
      7'd5:  k_d = 32'h59f111f1;
      7'd6:  k_d = 32'h923f82a4;
      7'd7:  k_d = 32'hab1c5ed5;
      7'd8:  k_d = 32'hd807aa98;
      7'd9:  k_d = 32'h12835b01;
      7'd10: k_d = 32'h243185be;
      7'd11: k_d = 32'h550c7dc3;
      7'd12: k_d = 32'h72be5d74;
      7'd13: k_d = 32'h80deb1fe;
      7'd14: k_d = 32'h9bdc06a7;
      7'd15: k_d = 32'hc19bf174;
      7'd16: k_d = 32'he49b69c1;
      7'd17: k_d = 32'hefbe4786;
      7'd18: k_d = 32'h0fc19dc6;
      7'd19: k_d = 32'h240ca1cc;
      7'd20: k_d = 32'h2de92c6f;
      7'd21: k_d = 32'h4a7484aa;
      7'd22: k_d = 32'h5cb0a9dc;
      7'd23: k_d = 32'h76f988da;
      7'd24: k_d = 32'h983e5152;
      7'd25: k_d = 32'ha831c66d;
      7'd26: k_d = 32'hb00327c8;
      7'd27: k_d = 32'hbf597fc7;
      7'd28: k_d = 32'hc6e00bf3;
      7'd29: k_d = 32'hd5a79147;
      7'd30: k_d = 32'h06ca6351;
      7'd31: k_d = 32'h14292967;
      7'd32: k_d = 32'h27b70a85;
      7'd33: k_d = 32'h2e1b2138;
      7'd34: k_d = 32'h4d2c6dfc;
      7'd35: k_d = 32'h53380d13;
      7'd36: k_d = 32'h650a7354;
      7'd37: k_d = 32'h766a0abb;
      7'd38: k_d = 32'h81c2c92e;
      7'd39: k_d = 32'h92722c85;
      7'd40: k_d = 32'ha2bfe8a1;
      7'd41: k_d = 32'ha81a664b;
      7'd42: k_d = 32'hc24b8b70;
      7'd43: k_d = 32'hc76c51a3;
      7'd44: k_d = 32'hd192e819;
      7'd45: k_d = 32'hd6990624;
      7'd46: k_d = 32'hf40e3585;
      7'd47: k_d = 32'h106aa070;
      7'd48: k_d = 32'h19a4c116;
      7'd49: k_d = 32'h1e376c08;
      7'd50: k_d = 32'h2748774c;
      7'd51: k_d = 32'h34b0bcb5;
      7'd52: k_d = 32'h391c0cb3;
      7'd53: k_d = 32'h4ed8aa4a;
      7'd54: k_d = 32'h5b9cca4f;
      7'd55: k_d = 32'h682e6ff3;
      7'd56: k_d = 32'h748f82ee;
      7'd57: k_d = 32'h78a5636f;
      7'd58: k_d = 32'h84c87814;
      7'd59: k_d = 32'h8cc70208;
      7'd60: k_d = 32'h90befffa;
      7'd61: k_d = 32'ha4506ceb;
      7'd62: k_d = 32'hbef9a3f7;
      7'd63: k_d = 32'hc67178f2;
      default: k_d = 32'h0000_0000;
    endcase
  end

  // K_t register; reset wins over any idx presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= 32'h0000_0000;
    end else begin
      k_q <= k_d;
    end
  end

  assign K_t = k_q;
  assign IV  = IvWord;

endmodule

// File: tb/tb_sha256_round_constants.sv
// Bench for sha256_round_constants: table-driven vectors through a scoreboard queue.
module tb_sha256_round_constants;
  import sha256_pkg::*;

  logic         clk;
  logic         rst;
  logic [6:0]   idx;
  logic [31:0]  K_t;
  logic [255:0] IV;

  localparam logic [255:0] IvRef =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  sha256_round_constants dut (
    .clk (clk),
    .rst (rst),
    .idx (idx),
    .K_t (K_t),
    .IV  (IV)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    string       name;
    logic        r;
    logic [6:0]  i;
    logic [31:0] exp;
  } vec_t;

  sb_t  exp_q[$];
  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; the expectation is queued for the next rising edge.
  task automatic drive(input logic r, input logic [6:0] i, input logic [31:0] e,
                       input string nm);
    sb_t s;
    @(negedge clk);
    rst = r;
    idx = i;
    s.name = nm;
    s.exp  = e;
    exp_q.push_back(s);
  endtask

  // Every queued entry was driven before this edge, so its result is visible just after it.
  always @(posedge clk) begin
    if (exp_q.size() != 0) begin
      sb_t s;
      s = exp_q.pop_front();
      #1;
      check(s.name, {224'd0, K_t}, {224'd0, s.exp});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idx = 7'd5;
    #1;
    check("iv_pre_reset", IV, IvRef);

    drive(1'b1, 7'd5, 32'h0000_0000, "reset_k");
    @(posedge clk);
    #2;
    check("iv_in_reset", IV, IvRef);

    // Latency: idx=0 must not show before the capturing edge.
    drive(1'b0, 7'd0, 32'h428a2f98, "idx0");
    check("idx0_not_early", {224'd0, K_t}, 256'd0);
    drive(1'b0, 7'd1, 32'h71374491, "idx1");

    vecs.push_back('{"idx15",  1'b0, 7'd15,  32'hc19bf174});
    vecs.push_back('{"idx16",  1'b0, 7'd16,  32'he49b69c1});
    vecs.push_back('{"idx32",  1'b0, 7'd32,  32'h27b70a85});
    vecs.push_back('{"idx48",  1'b0, 7'd48,  32'h19a4c116});
    vecs.push_back('{"idx63",  1'b0, 7'd63,  32'hc67178f2});
    vecs.push_back('{"idx64",  1'b0, 7'd64,  32'h0000_0000});
    vecs.push_back('{"idx100", 1'b0, 7'd100, 32'h0000_0000});
    vecs.push_back('{"idx127", 1'b0, 7'd127, 32'h0000_0000});
    vecs.push_back('{"idx2",   1'b0, 7'd2,   32'hb5c0fbcf});
    vecs.push_back('{"rst_idx63", 1'b1, 7'd63, 32'h0000_0000});
    vecs.push_back('{"post_rst_idx7", 1'b0, 7'd7, 32'hab1c5ed5});
    foreach (vecs[v]) drive(vecs[v].r, vecs[v].i, vecs[v].exp, vecs[v].name);

    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 7'(i), KTable[i], $sformatf("sweep%0d", i));
    end

    // Reset in the middle of a sweep, then resume at the same index.
    for (int i = 36; i < 40; i++) begin
      drive(1'b0, 7'(i), KTable[i], $sformatf("resweep%0d", i));
    end
    drive(1'b1, 7'd40, 32'h0000_0000, "midrst_k");
    check("iv_mid_reset", IV, IvRef);
    drive(1'b0, 7'd40, 32'ha2bfe8a1, "after_rst_idx40");
    drive(1'b0, 7'd41, 32'ha81a664b, "after_rst_idx41");

    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", 256'(exp_q.size()), 256'd0);
    check("iv_final", IV, IvRef);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_round_constants.md
Name: sha256_round_constants

Overview:
- Constant ROM for the SHA-256 core: supplies the per-round constant K_t for the round index and the 256-bit initial hash value IV (H0..H7).
- Constants as defined in FIPS 180-4 §4.2.2 (K) and §5.3.3 (IV).
- Sits beside the compression-round datapath. The controller drives idx one cycle ahead of the round that consumes K_t.

Parameters:
- None. All constants are fixed by the SHA-256 standard.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous reset, active-high
- idx  input  7  round index; 0..63 valid, 64..127 out of range
- K_t  output 32  registered round constant K[idx]
- IV   output 256  initial hash value, constant

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Sampled only on the rising edge of clk.
- K_t is a registered output:
  - At each rising clk edge with rst=1: K_t <= 32'h0000_0000.
  - At each rising clk edge with rst=0: K_t <= K[idx], where K is the 64-entry SHA-256 table (FIPS 180-4 §4.2.2), K[0]=428a2f98 … K[63]=c67178f2.
  - Latency: exactly 1 cycle from idx to K_t. K_t holds its value between edges.
- Out of range: for idx 64..127, K_t <= 32'h0000_0000. No wrap-around and no modulo-64.
- rst has priority over idx. An idx change in the same cycle as rst is ignored; the first valid K_t appears one cycle after rst deasserts.
- Reset mid-operation: K_t is 0 on the cycle after the reset edge. There is no other state.
- IV is purely combinational and constant. It is unaffected by rst and clk and is valid from time zero.
- IV packing, H0 in the MSBs:
  - IV[255:224]=6a09e667, IV[223:192]=bb67ae85, IV[191:160]=3c6ef372, IV[159:128]=a54ff53a
  - IV[127:96]=510e527f, IV[95:64]=9b05688c, IV[63:32]=1f83d9ab, IV[31:0]=5be0cd19
- No X propagation: every idx value maps to a defined K_t. The lookup must have a default branch giving 0.
- Implementation: a 64-entry case lookup feeding a 32-bit register. No RAM inference is required.

Decomposition:
- Shared package sha256_pkg holds:
  - the IV word constants H0..H7
  - a localparam count of 64 rounds
  - the 64 K word constants (optional), so other blocks and benches can reference the same values
- The module itself is a single flat block with no sub-modules. The combinational K lookup may be a function in the package (sha256_k(idx)) if the team prefers reuse.

Test Plan:
- Reset: rst=1, idx=5, one clk edge -> K_t=00000000. IV=6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19 both before and during reset.
- Lookup and latency: rst=0, idx=0 at edge n -> K_t=428a2f98 after edge n, not before. Then idx=1 -> 71374491 one edge later.
- Table spot checks:
  - idx=15 -> c19bf174
  - idx=16 -> e49b69c1
  - idx=32 -> 27b70a85
  - idx=48 -> 19a4c116
  - idx=63 -> c67178f2
- Sweep: idx 0..63 on consecutive cycles -> K_t follows the FIPS table with 1-cycle lag. Compare all 64 against the package constants.
- Out of range: idx=64, 100, 127 -> K_t=00000000 after the next edge. Then idx=2 -> b5c0fbcf.
- Reset mid-sweep: assert rst with idx=40 -> K_t=00000000 next cycle. Deassert rst with idx=40 -> K_t=a2bfe8a1 after the following edge. IV unchanged throughout.
